// File: rtl/bh_pkg.sv
// Shared types and constants for the bath-heater load sequencer.
// The state codes are visible on the state port, so their values are fixed.
package bh_pkg;

    localparam int TIMER_W = 13;

    localparam logic [3:0] MODE_VENT   = 4'b0001;
    localparam logic [3:0] MODE_WARM   = 4'b0010;
    localparam logic [3:0] MODE_STRONG = 4'b0100;
    localparam logic [3:0] MODE_DRY    = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_VENT    = 3'd1,
        S_LEAD    = 3'd2,
        S_HEAT1   = 3'd3,
        S_HEAT2   = 3'd4,
        S_DRY_ON  = 3'd5,
        S_DRY_OFF = 3'd6,
        S_PURGE   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        M_STBY,
        M_VENT,
        M_WARM,
        M_STRONG,
        M_DRY
    } mode_t;

    typedef struct packed {
        logic fan;
        logic heat1;
        logic heat2;
    } loads_t;

    // Anything other than exactly one set bit is standby.
    function automatic mode_t decode_mode(input logic [3:0] m);
        case (m)
            MODE_VENT:   return M_VENT;
            MODE_WARM:   return M_WARM;
            MODE_STRONG: return M_STRONG;
            MODE_DRY:    return M_DRY;
            default:     return M_STBY;
        endcase
    endfunction

    function automatic loads_t state_loads(input state_t s);
        case (s)
            S_VENT, S_LEAD, S_DRY_OFF, S_PURGE: return '{fan: 1'b1, heat1: 1'b0, heat2: 1'b0};
            S_HEAT1, S_DRY_ON:                  return '{fan: 1'b1, heat1: 1'b1, heat2: 1'b0};
            S_HEAT2:                            return '{fan: 1'b1, heat1: 1'b1, heat2: 1'b1};
            default:                            return '{fan: 1'b0, heat1: 1'b0, heat2: 1'b0};
        endcase
    endfunction

    // States in which at least one heating element is energised.
    function automatic logic is_heating(input state_t s);
        return (s == S_HEAT1) || (s == S_HEAT2) || (s == S_DRY_ON);
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond down-counter: loads on strobe, decrements on tick, stops at zero.
// o_expire flags the tick that consumes the last millisecond.
module ms_timer
    import bh_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_expire
);

    logic [TIMER_W-1:0] r_count;

    // Load wins over tick, so a tick in the entry cycle is not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_expire = i_tick && (r_count == TIMER_W'(1));

endmodule

// File: rtl/heater_power_sched.sv
// Sequences fan and two heater stages from the one-hot work mode, with fan lead,
// stage-2 stagger, dry-mode duty cycling, post-heat purge and overtemp lockout.
module heater_power_sched
    import bh_pkg::*;
#(
    parameter int FAN_LEAD_MS     = 500,
    parameter int STAGE_GAP_MS    = 1000,
    parameter int PURGE_WARM_MS   = 2000,
    parameter int PURGE_STRONG_MS = 4000,
    parameter int DRY_ON_MS       = 3000,
    parameter int DRY_OFF_MS      = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1ms,
    input  logic               en,
    input  logic [3:0]         mode,
    input  logic               overtemp,
    output logic               fan_en,
    output logic               heat1_en,
    output logic               heat2_en,
    output logic               purging,
    output logic               fault,
    output logic [2:0]         state,
    output logic [TIMER_W-1:0] remain_ms
);

    localparam logic [TIMER_W-1:0] LEAD_LEN         = TIMER_W'(FAN_LEAD_MS);
    localparam logic [TIMER_W-1:0] GAP_LEN          = TIMER_W'(STAGE_GAP_MS);
    localparam logic [TIMER_W-1:0] PURGE_WARM_LEN   = TIMER_W'(PURGE_WARM_MS);
    localparam logic [TIMER_W-1:0] PURGE_STRONG_LEN = TIMER_W'(PURGE_STRONG_MS);
    localparam logic [TIMER_W-1:0] DRY_ON_LEN       = TIMER_W'(DRY_ON_MS);
    localparam logic [TIMER_W-1:0] DRY_OFF_LEN      = TIMER_W'(DRY_OFF_MS);

    state_t             r_state;
    logic [3:0]         r_mode_q;
    logic               r_fault;
    logic               r_fan;
    logic               r_heat1;
    logic               r_heat2;
    logic               r_purging;

    state_t             w_next_state;
    mode_t              w_mode;
    logic               w_heat_req;
    logic               w_fault_next;
    logic [TIMER_W-1:0] w_purge_len;
    logic [TIMER_W-1:0] w_load_val;
    logic               w_load;
    logic [TIMER_W-1:0] w_count;
    logic               w_expire;
    loads_t             w_loads;

    assign w_mode     = decode_mode(r_mode_q);
    assign w_heat_req = (w_mode == M_WARM) || (w_mode == M_STRONG) || (w_mode == M_DRY);

    ms_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (tick_1ms),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_expire   (w_expire)
    );

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_purge_len  = PURGE_WARM_LEN;
        w_fault_next = r_fault;

        if (en && overtemp && is_heating(r_state)) begin
            w_fault_next = 1'b1;
        end else if ((w_mode == M_STBY) && !overtemp) begin
            w_fault_next = 1'b0;
        end

        if (!en) begin
            w_next_state = S_IDLE;
        end else if (overtemp && is_heating(r_state)) begin
            w_next_state = S_PURGE;
            w_purge_len  = PURGE_STRONG_LEN;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mode == M_VENT)            w_next_state = S_VENT;
                    else if (w_heat_req && !r_fault) w_next_state = S_LEAD;
                end
                S_VENT: begin
                    if (w_mode == M_STBY)            w_next_state = S_IDLE;
                    else if (w_mode == M_DRY && !r_fault) w_next_state = S_DRY_ON;
                    else if (w_heat_req && !r_fault) w_next_state = S_HEAT1;
                end
                S_LEAD: begin
                    if (w_mode == M_STBY)            w_next_state = S_IDLE;
                    else if (w_mode == M_VENT)       w_next_state = S_VENT;
                    else if (w_expire)               w_next_state = (w_mode == M_DRY) ? S_DRY_ON : S_HEAT1;
                end
                S_HEAT1: begin
                    // A gap that ran out while in warm lets strong promote at once.
                    if (!w_heat_req)                 w_next_state = S_PURGE;
                    else if (w_mode == M_DRY)        w_next_state = S_DRY_ON;
                    else if ((w_mode == M_STRONG) && (w_expire || (w_count == '0)))
                                                     w_next_state = S_HEAT2;
                end
                S_HEAT2: begin
                    if (!w_heat_req) begin
                        w_next_state = S_PURGE;
                        w_purge_len  = PURGE_STRONG_LEN;
                    end else if (w_mode == M_WARM)   w_next_state = S_HEAT1;
                    else if (w_mode == M_DRY)        w_next_state = S_DRY_ON;
                end
                S_DRY_ON, S_DRY_OFF: begin
                    if (!w_heat_req)                 w_next_state = S_PURGE;
                    else if (w_mode != M_DRY)        w_next_state = S_HEAT1;
                    else if (w_expire)               w_next_state = (r_state == S_DRY_ON) ? S_DRY_OFF : S_DRY_ON;
                end
                S_PURGE: begin
                    if (w_heat_req && !r_fault)      w_next_state = (w_mode == M_DRY) ? S_DRY_ON : S_HEAT1;
                    else if (w_expire)               w_next_state = (w_mode == M_VENT) ? S_VENT : S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Every state change reloads the timer; untimed states load zero.
    always_comb begin
        w_load_val = '0;
        case (w_next_state)
            S_LEAD:    w_load_val = LEAD_LEN;
            S_HEAT1:   w_load_val = GAP_LEN;
            S_DRY_ON:  w_load_val = DRY_ON_LEN;
            S_DRY_OFF: w_load_val = DRY_OFF_LEN;
            S_PURGE:   w_load_val = w_purge_len;
            default:   w_load_val = '0;
        endcase
    end

    assign w_load = (w_next_state != r_state);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_mode_q <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_mode_q <= mode;
            r_fault  <= w_fault_next;
        end
    end

    assign w_loads = state_loads(r_state);

    // Loads follow the state one clock later; en and overtemp also cut drive on the same edge the state leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fan     <= 1'b0;
            r_heat1   <= 1'b0;
            r_heat2   <= 1'b0;
            r_purging <= 1'b0;
        end else begin
            r_fan     <= en && w_loads.fan;
            r_heat1   <= en && !overtemp && w_loads.heat1;
            r_heat2   <= en && !overtemp && w_loads.heat2;
            r_purging <= en && (r_state == S_PURGE);
        end
    end

    assign fan_en    = r_fan;
    assign heat1_en  = r_heat1;
    assign heat2_en  = r_heat2;
    assign purging   = r_purging;
    assign fault     = r_fault;
    assign state     = r_state;
    assign remain_ms = w_count;

endmodule
